// File: rtl/pcie_pkg.sv
// pcie_pkg: shared definitions for the PCIe transmit scheduler.
//   pcie_state_e  link/scheduler state encoding
//   CTRL_*        lane CONTROL codes (training, idle, data)
//   state_ctrl()  CONTROL code a state shows on the lane when no beat is sent
package pcie_pkg;

  typedef enum logic [2:0] {
    L_IDLE      = 3'd0,
    TS1         = 3'd1,
    TS2         = 3'd2,
    TS3         = 3'd3,
    TS4         = 3'd4,
    ACTIVE_IDLE = 3'd5,
    SEND        = 3'd6
  } pcie_state_e;

  localparam logic [3:0] CTRL_IDLE = 4'd0;
  localparam logic [3:0] CTRL_TS1  = 4'd1;
  localparam logic [3:0] CTRL_TS2  = 4'd2;
  localparam logic [3:0] CTRL_TS3  = 4'd3;
  localparam logic [3:0] CTRL_TS4  = 4'd4;
  localparam logic [3:0] CTRL_DATA = 4'd9;

  // L_IDLE, ACTIVE_IDLE and a stalled SEND all show the idle code.
  function automatic logic [3:0] state_ctrl(input pcie_state_e s);
    case (s)
      TS1:     return CTRL_TS1;
      TS2:     return CTRL_TS2;
      TS3:     return CTRL_TS3;
      TS4:     return CTRL_TS4;
      default: return CTRL_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/pcie_rr_arbiter.sv
// pcie_rr_arbiter: two-requester round-robin arbiter, packet granularity.
//   clk, rst_n   clock, asynchronous active-low reset
//   req[1:0]     requester valids
//   pkt_done     last beat of a packet accepted this cycle
//   done_owner   requester that owned the finishing packet
//   winner       requester that wins if a grant is taken this cycle
// A lone requester always wins; with both requesting, the pointer holder
// wins. The pointer hands priority to the other requester at packet end.
module pcie_rr_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       pkt_done,
  input  logic       done_owner,
  output logic       winner
);

  logic ptr;

  always_comb begin
    winner = ptr;
    if (req == 2'b01) winner = 1'b0;
    else if (req == 2'b10) winner = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= 1'b0;
    else if (pkt_done) ptr <= ~done_owner;
  end

endmodule

// File: rtl/pcie_tx_scheduler.sv
// pcie_tx_scheduler: transmit-side link controller for the PCIe lane model.
// Trains the link (CONTROL 0,1,2,3,4), then arbitrates two packet requesters
// round-robin at packet granularity onto the shared DATA/Valid/CONTROL lane.
//
// Ports:
//   CLK, reset_L            clock, asynchronous active-low reset
//   link_en                 request link training / keep link up
//   reqN_data/valid/last    requester beat, beat valid, last beat of packet
//   reqN_ready              beat accepted when valid && ready (combinational)
//   credit_ret, credits     packet credit return / count (PCIE_SCHED_CREDIT_EN)
//   DATA, Valid, CONTROL    registered lane outputs
//   link_up                 registered: link in ACTIVE_IDLE or SEND
//   grant                   current or last packet owner
//   state_dbg               current FSM state
//
// Handshake: a beat transfers on a rising edge where reqN_valid && reqN_ready.
// Ready depends only on state and grant (never on valid), is high only for
// the granted requester in SEND, and a requester may drop valid mid-packet
// to stall; the lane then shows Valid=0/CONTROL=0 until valid returns.
//
// Optional feature macro: PCIE_SCHED_CREDIT_EN adds the packet credit counter.
module pcie_tx_scheduler
  import pcie_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int IDLE_CYCLES = 4,
  parameter int CREDIT_W    = 4,
  parameter int CREDIT_INIT = 8
) (
  input  logic              CLK,
  input  logic              reset_L,
  input  logic              link_en,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req0_valid,
  input  logic              req1_valid,
  input  logic              req0_last,
  input  logic              req1_last,
  output logic              req0_ready,
  output logic              req1_ready,
  output logic [DATA_W-1:0] DATA,
  output logic              Valid,
  output logic [3:0]        CONTROL,
  output logic              link_up,
  output logic              grant,
`ifdef PCIE_SCHED_CREDIT_EN
  input  logic              credit_ret,
  output logic [CREDIT_W-1:0] credits,
`endif
  output pcie_state_e       state_dbg
);

  localparam int CNT_W = $clog2(IDLE_CYCLES + 1);

  if (CREDIT_INIT >= (1 << CREDIT_W)) begin : g_credit_init_check
    $error("CREDIT_INIT must be representable in CREDIT_W bits");
  end

  pcie_state_e       state, state_next;
  logic [CNT_W-1:0]  idle_cnt, idle_cnt_next;
  logic              accept;
  logic              beat_last;
  logic [DATA_W-1:0] beat_data;
  logic              pkt_done;
  logic              can_arb;
  logic              grant_take;
  logic              winner;
  logic              credit_ok;

  // Beat path: everything follows the latched grant.
  assign beat_data  = grant ? req1_data : req0_data;
  assign beat_last  = grant ? req1_last : req0_last;
  assign req0_ready = (state == SEND) && !grant;
  assign req1_ready = (state == SEND) && grant;
  assign accept     = (state == SEND) && (grant ? req1_valid : req0_valid);
  assign pkt_done   = accept && beat_last;

  assign can_arb    = (req0_valid || req1_valid) && credit_ok;
  assign grant_take = (state == ACTIVE_IDLE) && link_en && can_arb;
  assign state_dbg  = state;

  pcie_rr_arbiter u_arb (
    .clk        (CLK),
    .rst_n      (reset_L),
    .req        ({req1_valid, req0_valid}),
    .pkt_done   (pkt_done),
    .done_owner (grant),
    .winner     (winner)
  );

  always_comb begin
    state_next    = state;
    idle_cnt_next = '0;
    case (state)
      L_IDLE: begin
        if (link_en) begin
          if (idle_cnt == CNT_W'(IDLE_CYCLES - 1)) state_next = TS1;
          else idle_cnt_next = idle_cnt + 1'b1;
        end
      end
      TS1:         state_next = link_en ? TS2 : L_IDLE;
      TS2:         state_next = link_en ? TS3 : L_IDLE;
      TS3:         state_next = link_en ? TS4 : L_IDLE;
      TS4:         state_next = link_en ? ACTIVE_IDLE : L_IDLE;
      ACTIVE_IDLE: begin
        if (!link_en) state_next = L_IDLE;
        else if (can_arb) state_next = SEND;
      end
      // link_en is deliberately not looked at until the packet completes.
      SEND:        if (pkt_done) state_next = ACTIVE_IDLE;
      default:     state_next = L_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset_L) begin
    if (!reset_L) begin
      state    <= L_IDLE;
      idle_cnt <= '0;
      grant    <= 1'b0;
    end else begin
      state    <= state_next;
      idle_cnt <= idle_cnt_next;
      if (grant_take) grant <= winner;
    end
  end

  // Lane registers reflect the cycle just ended, so link_up and CONTROL
  // both trail the state register by one cycle.
  always_ff @(posedge CLK or negedge reset_L) begin
    if (!reset_L) begin
      DATA    <= '0;
      Valid   <= 1'b0;
      CONTROL <= CTRL_IDLE;
      link_up <= 1'b0;
    end else begin
      link_up <= (state == ACTIVE_IDLE) || (state == SEND);
      if (accept) begin
        DATA    <= beat_data;
        Valid   <= 1'b1;
        CONTROL <= CTRL_DATA;
      end else begin
        DATA    <= '0;
        Valid   <= 1'b0;
        CONTROL <= state_ctrl(state);
      end
    end
  end

`ifdef PCIE_SCHED_CREDIT_EN
  assign credit_ok = (credits != '0);

  // A grant and a return in the same cycle cancel out.
  always_ff @(posedge CLK or negedge reset_L) begin
    if (!reset_L) begin
      credits <= CREDIT_W'(CREDIT_INIT);
    end else begin
      case ({grant_take, credit_ret})
        2'b10:   credits <= credits - 1'b1;
        2'b01:   if (credits != CREDIT_W'(CREDIT_INIT)) credits <= credits + 1'b1;
        default: credits <= credits;
      endcase
    end
  end
`else
  assign credit_ok = 1'b1;
`endif

endmodule

// File: doc/pcie_tx_scheduler.md
# pcie_tx_scheduler

Transmit-side link controller for the PCIe lane model. After reset it sequences the link through its training codes on CONTROL (0, 1, 2, 3, 4). It then arbitrates two packet requesters round-robin at packet granularity and drives the shared DATA/Valid/CONTROL lane, with CONTROL=9 marking data beats. It sits between the requester logic and the lane, and it owns the only driver of DATA, Valid and CONTROL.

## Interface
- DATA_W, 8, lane data width
- IDLE_CYCLES, 4, cycles of CONTROL=0 with link_en high before TS1
- CREDIT_W, 4, credit counter width
- CREDIT_INIT, 8, reset and maximum credit count in packets (must be < 2^CREDIT_W)

- CLK  in  1  clock; all state changes on rising edge
- reset_L  in  1  asynchronous, active-low reset
- link_en  in  1  request link training and keep the link up
- req0_data / req1_data  in  DATA_W  requester beat
- req0_valid / req1_valid  in  1  beat valid
- req0_last / req1_last  in  1  beat is the last of its packet
- req0_ready / req1_ready  out  1  beat accepted when valid&&ready (combinational)
- credit_ret  in  1  downstream returns one packet credit (PCIE_SCHED_CREDIT_EN only)
- DATA  out  DATA_W  lane data, registered
- Valid  out  1  lane beat valid, registered
- CONTROL  out  4  lane control code, registered
- link_up  out  1  high in ACTIVE_IDLE and SEND
- grant  out  1  current or last packet owner
- credits  out  CREDIT_W  available credits (PCIE_SCHED_CREDIT_EN only)

## Operation
- States: L_IDLE, TS1, TS2, TS3, TS4, ACTIVE_IDLE, SEND.
- L_IDLE:
  - counts consecutive cycles with link_en=1;
  - after IDLE_CYCLES such cycles it goes to TS1;
  - link_en=0 clears the count.
- TS1 through TS4 last one cycle each, then ACTIVE_IDLE. If link_en=0 in any TS state, go to L_IDLE.
- ACTIVE_IDLE:
  - link_en=0 goes to L_IDLE;
  - otherwise, if any reqN_valid (and credits>0 when the credit macro is on), arbitrate, latch grant and go to SEND.
- Arbitration: round-robin with a one-bit priority pointer.
  - If only one requester is valid, it wins.
  - If both are valid, the pointer holder wins.
  - The pointer moves to the other requester when a packet's last beat is accepted.
- SEND:
  - req[grant]_ready=1 and the other ready=0;
  - each accepted beat is forwarded;
  - when the beat with last=1 is accepted, go to ACTIVE_IDLE;
  - link_en=0 is ignored until the packet completes.
- Ready is 0 in every state except SEND.
- Lane output registers, updated every cycle:
  - beat accepted this cycle: next cycle DATA=beat, Valid=1, CONTROL=9;
  - otherwise: DATA=0, Valid=0, CONTROL = code of the current state (L_IDLE/ACTIVE_IDLE/SEND-stall → 0, TSn → n).

## Timing
- Reset values: DATA=0, Valid=0, CONTROL=0, link_up=0, grant=0, priority pointer=0, idle count=0, credits=CREDIT_INIT, state L_IDLE.
- Reset is asynchronous: all outputs go to their reset values immediately, and any in-flight packet is dropped.
- With link_en held high from reset release, CONTROL reads 0×(IDLE_CYCLES+1), then 1, 2, 3, 4, then 0.
- Latency:
  - grant decision in ACTIVE_IDLE; SEND is entered the next cycle;
  - the beat accepted in cycle t appears on the lane in cycle t+1;
  - there is a minimum one-cycle Valid=0 gap between packets.
- A mid-packet valid drop stalls without penalty: Valid=0 and CONTROL=0 for those cycles, and the grant is held.

## Configuration
- PCIE_SCHED_CREDIT_EN defined:
  - credits counter exists; it decrements by 1 when a packet is granted and increments by 1 on credit_ret;
  - grant and credit_ret in the same cycle leave it unchanged;
  - increments saturate at CREDIT_INIT;
  - credits=0 blocks arbitration in ACTIVE_IDLE.
- PCIE_SCHED_CREDIT_EN undefined: the credit_ret and credits ports and the counter are absent, and arbitration is never blocked.

## Structure
- Shared package pcie_pkg:
  - state enum;
  - CONTROL codes CTRL_IDLE=0, CTRL_TS1..CTRL_TS4=1..4, CTRL_DATA=9.
- Sub-module pcie_rr_arbiter: two-request round-robin arbiter with a pointer update on packet end, instantiated once.

## Test plan
- Training: release reset with link_en=1 → CONTROL sequence 0,0,0,0,0,1,2,3,4,0 and link_up high from the 10th cycle. Dropping link_en in TS2 → CONTROL=0 and restart from L_IDLE.
- Single packet: req0 sends AA,BB,CC,DD (last on DD) → lane shows CONTROL=9, Valid=1, DATA AA,BB,CC,DD on consecutive cycles, each one cycle after its acceptance.
- Contention: both requesters hold 2-beat packets continuously → grants alternate 0,1,0,1, with one idle cycle between packets.
- Stall: req1 drops valid for 2 cycles mid-packet → Valid=0 and CONTROL=0 for 2 cycles, grant stays 1, and the packet resumes intact.
- Credits (macro on, CREDIT_INIT=2): three packets queued with no credit_ret → two sent and the third blocked. One credit_ret → the third is sent. Simultaneous grant and credit_ret → count unchanged.
- Async reset during SEND → all outputs 0 immediately with no clock edge, credits=CREDIT_INIT, and training restarts.
